uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmitter with an input FIFO: 8 data bits, one start bit, one stop bit, LSB first, and an optional even parity bit. Bytes are pushed through a valid/ready handshake and serialized back-to-back. This block is the transmit counterpart of the FPGA debug UART receiver and drives the board TX pin from the SDIO-side logic.

## Interface
- CLKS_PER_BIT, 434, clocks per bit: i_Clock frequency / baud. Legal range 4..1023, so it fits a 10-bit counter.
- FIFO_AW, 3, FIFO address width. Depth is 2**FIFO_AW, legal range 1..6.
- i_Clock  in  1  system clock; all logic is rising-edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; a byte is accepted on any cycle where i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  in  8  byte to enqueue.
- o_Tx_Ready  out  1  FIFO not full; combinational from the registered count.
- o_Fifo_Count  out  FIFO_AW+1  number of bytes held, not counting the byte being shifted.
- o_Tx_Serial  out  1  serial line, registered, idles high.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Done  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- FIFO: circular buffer with wr_ptr, rd_ptr and count.
  - Write when i_Tx_DV && count != DEPTH.
  - Pop only from the IDLE/STOP-end decision described below.
  - Simultaneous write and pop: count is unchanged and both pointers advance.
  - A write while full is dropped silently; o_Tx_Ready=0 warns the sender.
- State machine (r_SM):
  - IDLE: line high, o_Tx_Active=0. If count!=0: pop into the shift register, go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: line = shift[idx] for CLKS_PER_BIT cycles per bit, idx 0..7. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (macro only): line = ^byte (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. In the final cycle, pulse o_Tx_Done. Then:
    - if count!=0: pop and go straight to START, with no idle gap;
    - else go to IDLE.
- Bit counter: 10 bits, counts 0..CLKS_PER_BIT-1, resets to 0 on every state or bit change. It never wraps.
- Reset values:
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0;
  - count=0, so o_Tx_Ready=1 and o_Fifo_Count=0;
  - pointers=0, r_SM=IDLE.
- Reset mid-frame: the line returns high immediately (asynchronous) and queued bytes are discarded. The next frame starts only after a new write.

## Timing
- Latency: a byte accepted at edge N into an empty FIFO while IDLE.
  - Count becomes 1 at N+1.
  - IDLE pops at N+1; the state is START and the line is low from N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit follows the previous stop bit with zero extra cycles.
- o_Tx_Active:
  - high from the first START cycle through the last STOP cycle;
  - stays high across back-to-back frames.
- o_Tx_Ready returns high the cycle after a pop from a full FIFO. A same-cycle pop does not enable a write while full.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in and an even parity bit follows bit 7, giving 11-bit frames.
  - Undefined: the PARITY state and its logic are absent, giving 8N1 frames of 10 bits.

## Test plan
- Reset, then idle for 100 cycles -> o_Tx_Serial=1, o_Tx_Ready=1, o_Fifo_Count=0, o_Tx_Done never pulses.
- Single byte 0x35, CLKS_PER_BIT=4:
  - line low 2 cycles after the write;
  - bits 1,0,1,0,1,1,0,0 LSB first, each 4 cycles, then 1 for 4 cycles;
  - o_Tx_Done pulses once, 40 cycles after the start bit begins.
- Burst 0xA5, 0x00, 0xFF written on consecutive cycles -> three contiguous frames, no idle gap, o_Tx_Active continuously high for 120 cycles, three o_Tx_Done pulses.
- FIFO_AW=2, write 6 bytes back-to-back with i_Tx_DV held high:
  - 1 byte pops and 4 are queued;
  - o_Tx_Ready=0 from then on, and the 6th byte is dropped;
  - exactly 5 frames are emitted, in order.
- Assert i_Reset mid-way through DATA of 0x55 with 2 bytes queued -> line high in the same cycle, count=0, no further frames after reset deasserts.
- With UART_TX_PARITY_EN defined, send 0x07 then 0x03 -> parity bits 1 then 0, frames 44 cycles each with CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake between a sender (master) and uart_tx_fifo (slave).
// A byte moves on any cycle where i_Tx_DV && o_Tx_Ready; o_Fifo_Count reports queue depth.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 3
);
  logic               i_Tx_DV;
  logic [7:0]         i_Tx_Byte;
  logic               o_Tx_Ready;
  logic [FIFO_AW:0]   o_Fifo_Count;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter, 8N1 LSB first (8E1 when UART_TX_PARITY_EN is defined); line low 2 cycles after a write.
// Back-to-back frames with no gap; o_Tx_Ready drops while full and writes then are dropped.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_fifo_if.slave io_Tx,
  output logic          o_Tx_Serial,
  output logic          o_Tx_Active,
  output logic          o_Tx_Done
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [9:0]       LAST_CLK = 10'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } sm_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } sm_t;
`endif

  logic [7:0]         r_Mem [DEPTH];
  logic [FIFO_AW-1:0] r_Wr_Ptr;
  logic [FIFO_AW-1:0] r_Rd_Ptr;
  logic [FIFO_AW:0]   r_Count;
  logic [7:0]         r_Shift;

  sm_t                r_SM;
  sm_t                w_SM_Next;
  logic [9:0]         r_Clk_Cnt;
  logic [9:0]         w_Clk_Cnt_Next;
  logic [2:0]         r_Bit_Idx;
  logic [2:0]         w_Bit_Idx_Next;

  logic               w_Wr;
  logic               w_Pop;
  logic               w_Not_Empty;
  logic               w_Bit_End;
  logic               w_Serial;
  logic               w_Active;
  logic               w_Done;

  assign w_Not_Empty          = (r_Count != '0);
  assign w_Bit_End            = (r_Clk_Cnt == LAST_CLK);
  assign w_Wr                 = io_Tx.i_Tx_DV && (r_Count != FULL);
  assign io_Tx.o_Tx_Ready     = (r_Count != FULL);
  assign io_Tx.o_Fifo_Count   = r_Count;

  // FIFO bookkeeping; a pop moves the head byte straight into the shift register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
      r_Shift  <= '0;
    end else begin
      if (w_Wr) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
        r_Shift  <= r_Mem[r_Rd_Ptr];
      end
      if (w_Wr && !w_Pop) begin
        r_Count <= r_Count + 1'b1;
      end else if (!w_Wr && w_Pop) begin
        r_Count <= r_Count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_Wr) begin
      r_Mem[r_Wr_Ptr] <= io_Tx.i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_SM      <= S_IDLE;
      r_Clk_Cnt <= '0;
      r_Bit_Idx <= '0;
    end else begin
      r_SM      <= w_SM_Next;
      r_Clk_Cnt <= w_Clk_Cnt_Next;
      r_Bit_Idx <= w_Bit_Idx_Next;
    end
  end

  always_comb begin
    w_SM_Next      = r_SM;
    w_Clk_Cnt_Next = r_Clk_Cnt + 10'd1;
    w_Bit_Idx_Next = r_Bit_Idx;
    w_Pop          = 1'b0;
    case (r_SM)
      S_IDLE: begin
        w_Clk_Cnt_Next = '0;
        if (w_Not_Empty) begin
          w_Pop     = 1'b1;
          w_SM_Next = S_START;
        end
      end
      S_START: begin
        if (w_Bit_End) begin
          w_SM_Next      = S_DATA;
          w_Clk_Cnt_Next = '0;
          w_Bit_Idx_Next = '0;
        end
      end
      S_DATA: begin
        if (w_Bit_End) begin
          w_Clk_Cnt_Next = '0;
          if (r_Bit_Idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_SM_Next = S_PARITY;
`else
            w_SM_Next = S_STOP;
`endif
          end else begin
            w_Bit_Idx_Next = r_Bit_Idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_Bit_End) begin
          w_SM_Next      = S_STOP;
          w_Clk_Cnt_Next = '0;
        end
      end
`endif
      S_STOP: begin
        // Popping here instead of via IDLE is what keeps queued frames gap-free.
        if (w_Bit_End) begin
          w_Clk_Cnt_Next = '0;
          if (w_Not_Empty) begin
            w_Pop     = 1'b1;
            w_SM_Next = S_START;
          end else begin
            w_SM_Next = S_IDLE;
          end
        end
      end
      default: begin
        w_SM_Next      = S_IDLE;
        w_Clk_Cnt_Next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line lines up with r_SM.
  always_comb begin
    w_Serial = 1'b1;
    w_Active = (w_SM_Next != S_IDLE);
    w_Done   = 1'b0;
    case (w_SM_Next)
      S_START:  w_Serial = 1'b0;
      S_DATA:   w_Serial = r_Shift[w_Bit_Idx_Next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_Serial = ^r_Shift;
`endif
      S_STOP:   w_Done   = (w_Clk_Cnt_Next == LAST_CLK);
      default:  w_Serial = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Serial <= w_Serial;
      o_Tx_Active <= w_Active;
      o_Tx_Done   <= w_Done;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial;
  logic active;
  logic done;

  uart_tx_fifo_if #(.FIFO_AW(AW)) tx_if ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .io_Tx       (tx_if),
    .o_Tx_Serial (serial),
    .o_Tx_Active (active),
    .o_Tx_Done   (done)
  );

  always #5 clk = ~clk;

  int         n_pass   = 0;
  int         n_total  = 0;
  logic [7:0] exp_q[$];
  bit         par_q[$];
  int         done_cnt = 0;
  int         m_starts = 0;
  int         m_cyc    = 0;
  bit         m_busy   = 1'b0;
  bit         m_bad    = 1'b0;
  bit         m_ok;
  logic [15:0] m_bits  = '0;
  logic [7:0] m_data;
  logic [7:0] m_exp;
  int         act_run  = 0;
  int         last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Line monitor: decodes each frame cycle by cycle and checks it against the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (active === 1'b1) act_run++;
    else begin
      if (act_run > 0) last_run = act_run;
      act_run = 0;
    end
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy && serial === 1'b0) begin
        m_busy = 1'b1;
        m_cyc  = 0;
        m_bad  = 1'b0;
        m_starts++;
      end
      if (m_busy) begin
        if (m_cyc % CPB == 0) m_bits[m_cyc / CPB] = serial;
        else if (serial !== m_bits[m_cyc / CPB]) m_bad = 1'b1;
        if (active !== 1'b1) m_bad = 1'b1;
        if ((m_cyc == FRAME - 1) != (done === 1'b1)) m_bad = 1'b1;
        if (m_cyc == FRAME - 1) begin
          m_data = m_bits[8:1];
          m_ok   = !m_bad && (m_bits[0] === 1'b0) && (m_bits[NB-1] === 1'b1);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL frame_unexpected: got frame 0x%0h, expected no frame", m_data);
          end else begin
            m_exp = exp_q.pop_front();
            chk("frame_data", 32'(m_data), 32'(m_exp));
`ifdef UART_TX_PARITY_EN
            if (m_bits[9] !== ^m_exp) m_ok = 1'b0;
            par_q.push_back(m_bits[9]);
`endif
            chk("frame_shape", 32'(m_ok), 32'd1);
          end
          m_busy = 1'b0;
        end
        m_cyc++;
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_total++;
      $display("FAIL drain_timeout: %0d frames pending after %0d cycles, expected 0", exp_q.size(), budget);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected it to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int s0;
    int n;

    tx_if.i_Tx_DV   = 1'b0;
    tx_if.i_Tx_Byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(serial), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    rst = 1'b0;

    repeat (100) @(negedge clk);
    chk("idle_serial", 32'(serial), 32'd1);
    chk("idle_ready",  32'(tx_if.o_Tx_Ready), 32'd1);
    chk("idle_count",  32'(tx_if.o_Fifo_Count), 32'd0);
    chk("idle_done",   32'(done_cnt), 32'd0);

    // Single byte 0x35: count 1 next cycle, start bit the cycle after.
    d0 = done_cnt;
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Byte = 8'h35;
    exp_q.push_back(8'h35);
    @(negedge clk);
    tx_if.i_Tx_DV = 1'b0;
    chk("lat_count", 32'(tx_if.o_Fifo_Count), 32'd1);
    chk("lat_line_high", 32'(serial), 32'd1);
    @(negedge clk);
    chk("lat_line_low", 32'(serial), 32'd0);
    drain(200);
    chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("single_active_len", 32'(last_run), 32'(FRAME));

    // Burst of three: one unbroken active run of three frames.
    d0 = done_cnt;
    tx_if.i_Tx_DV = 1'b1;
    tx_if.i_Tx_Byte = 8'hA5; exp_q.push_back(8'hA5); @(negedge clk);
    tx_if.i_Tx_Byte = 8'h00; exp_q.push_back(8'h00); @(negedge clk);
    tx_if.i_Tx_Byte = 8'hFF; exp_q.push_back(8'hFF); @(negedge clk);
    tx_if.i_Tx_DV = 1'b0;
    drain(600);
    chk("burst_active_len", 32'(last_run), 32'(3 * FRAME));
    chk("burst_done_cnt", 32'(done_cnt - d0), 32'd3);

    // Six writes into a depth-4 FIFO: first pops, four queue, sixth dropped.
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      chk("fifo_ready", 32'(tx_if.o_Tx_Ready), (i < 5) ? 32'd1 : 32'd0);
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = 8'(8'h11 + i);
      @(negedge clk);
    end
    tx_if.i_Tx_DV = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h15);
    chk("fifo_full_count", 32'(tx_if.o_Fifo_Count), 32'd4);
    repeat (5) @(negedge clk);
    chk("fifo_full_ready", 32'(tx_if.o_Tx_Ready), 32'd0);
    drain(1000);
    chk("fifo_done_cnt", 32'(done_cnt - d0), 32'd5);
    chk("fifo_empty_count", 32'(tx_if.o_Fifo_Count), 32'd0);

    // Reset in the middle of 0x55 with 0x66, 0x77 queued: nothing may follow.
    tx_if.i_Tx_DV = 1'b1;
    tx_if.i_Tx_Byte = 8'h55; @(negedge clk);
    tx_if.i_Tx_Byte = 8'h66; @(negedge clk);
    tx_if.i_Tx_Byte = 8'h77; @(negedge clk);
    tx_if.i_Tx_DV = 1'b0;
    n = 0;
    while (!m_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL rst_mid_start: no start bit after %0d cycles, expected one", n);
    end
    repeat (12) @(negedge clk);
    chk("rst_mid_pre_count", 32'(tx_if.o_Fifo_Count), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_serial", 32'(serial), 32'd1);
    chk("rst_mid_active", 32'(active), 32'd0);
    chk("rst_mid_count",  32'(tx_if.o_Fifo_Count), 32'd0);
    chk("rst_mid_ready",  32'(tx_if.o_Tx_Ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0 = m_starts;
    d0 = done_cnt;
    repeat (100) @(negedge clk);
    chk("post_rst_starts", 32'(m_starts - s0), 32'd0);
    chk("post_rst_done",   32'(done_cnt - d0), 32'd0);
    chk("post_rst_serial", 32'(serial), 32'd1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones -> parity 1; 0x03 has two -> parity 0.
    par_q.delete();
    tx_if.i_Tx_DV = 1'b1;
    tx_if.i_Tx_Byte = 8'h07; exp_q.push_back(8'h07); @(negedge clk);
    tx_if.i_Tx_Byte = 8'h03; exp_q.push_back(8'h03); @(negedge clk);
    tx_if.i_Tx_DV = 1'b0;
    drain(400);
    chk("par_frames", 32'(par_q.size()), 32'd2);
    if (par_q.size() == 2) begin
      chk("par_bit0", 32'(par_q[0]), 32'd1);
      chk("par_bit1", 32'(par_q[1]), 32'd0);
    end
    chk("par_active_len", 32'(last_run), 32'd88);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
